// File: rtl/seq_mag_cmp.sv
// Digit-serial MSB-first unsigned magnitude comparator with a start/ready/done handshake.
// Optional macro SEQ_MAG_CMP_EARLY_EXIT_EN stops at the first differing digit; otherwise latency is fixed at N digits.
module seq_mag_cmp #(
  parameter  int W  = 8,
  parameter  int D  = 2,
  localparam int N  = W / D,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          ready,
  output logic          done,
  output logic          agtb,
  output logic          aeqb,
  output logic          altb,
  output logic [CW-1:0] digits
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_sr_q, a_sr_d;
  logic [W-1:0]    b_sr_q, b_sr_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic            done_q, done_d;
  logic            agtb_q, agtb_d;
  logic            aeqb_q, aeqb_d;
  logic            altb_q, altb_d;
  logic [CW-1:0]   digits_q, digits_d;

  logic [D-1:0]    dig_a, dig_b;
  logic            dig_ne, dig_gt, last_dig;
  logic            stop, res_ne, res_gt;
  logic [CW-1:0]   dig_cnt;

  assign dig_a    = a_sr_q[W-1 -: D];
  assign dig_b    = b_sr_q[W-1 -: D];
  assign dig_ne   = (dig_a != dig_b);
  assign dig_gt   = (dig_a > dig_b);
  assign last_dig = (idx_q == CW'(N - 1));

`ifdef SEQ_MAG_CMP_EARLY_EXIT_EN
  assign stop    = dig_ne | last_dig;
  assign res_ne  = dig_ne;
  assign res_gt  = dig_gt;
  assign dig_cnt = idx_q + CW'(1);
`else
  // The first differing digit is remembered so the scan can run to the end.
  logic found_q, found_d;
  logic fgt_q, fgt_d;

  assign stop    = last_dig;
  assign res_ne  = found_q | dig_ne;
  assign res_gt  = found_q ? fgt_q : dig_gt;
  assign dig_cnt = CW'(N);

  always_comb begin
    found_d = found_q;
    fgt_d   = fgt_q;
    if (state_q == ST_IDLE && start) begin
      found_d = 1'b0;
      fgt_d   = 1'b0;
    end else if (state_q == ST_RUN && !found_q && dig_ne) begin
      found_d = 1'b1;
      fgt_d   = dig_gt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      found_q <= 1'b0;
      fgt_q   <= 1'b0;
    end else begin
      found_q <= found_d;
      fgt_q   <= fgt_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    agtb_d   = agtb_q;
    aeqb_d   = aeqb_q;
    altb_d   = altb_q;
    digits_d = digits_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          agtb_d   = res_ne & res_gt;
          altb_d   = res_ne & ~res_gt;
          aeqb_d   = ~res_ne;
          digits_d = dig_cnt;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          a_sr_d = a_sr_q << D;
          b_sr_d = b_sr_q << D;
          idx_d  = idx_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      agtb_q   <= 1'b0;
      aeqb_q   <= 1'b0;
      altb_q   <= 1'b0;
      digits_q <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      agtb_q   <= agtb_d;
      aeqb_q   <= aeqb_d;
      altb_q   <= altb_d;
      digits_q <= digits_d;
    end
  end

  assign ready  = (state_q == ST_IDLE);
  assign done   = done_q;
  assign agtb   = agtb_q;
  assign aeqb   = aeqb_q;
  assign altb   = altb_q;
  assign digits = digits_q;

endmodule

// File: doc/seq_mag_cmp.md
Name: seq_mag_cmp

Overview:
Parametrised sequential magnitude comparator; next generation of the team's 2-bit combinational greater-than block.
Compares two W-bit unsigned operands digit-serially, MSB-first, D bits per clock, under a start/ready/done handshake.
Produces one-hot gt/eq/lt flags plus the number of digits examined.
Intended for datapaths where W is too wide for a single-cycle compare at the target clock.

Parameters:
W, 8, operand width in bits; must be a multiple of D, W >= 2
D, 2, digit width compared per clock; 1 <= D <= W
(derived) N = W/D digits; CW = clog2(N+1), width of the digit count

Ports:
clk  in  1  system clock, rising-edge
reset_n  in  1  asynchronous active-low reset
start  in  1  request a compare; sampled only when ready=1
a  in  W  operand A; captured at the accepting edge
b  in  W  operand B; captured at the accepting edge
ready  out  1  high in IDLE only
done  out  1  one-cycle pulse when a result is valid
agtb  out  1  A > B
aeqb  out  1  A == B
altb  out  1  A < B
digits  out  CW  digits examined for the last result (1..N)

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, ready=1, done=0, agtb=aeqb=altb=0, digits=0, internal shift regs and index cleared.
- Reset mid-compare aborts the operation. No done pulse and no result update occur.
- Three-state FSM: IDLE, RUN, DONE.
- IDLE: at an edge with start=1, a->a_sr, b->b_sr, idx<=0, go to RUN.
- In IDLE with start=0, stay in IDLE. Result outputs hold their last values.
- RUN: at each edge, compare the top digits a_sr[W-1 -: D] and b_sr[W-1 -: D] as unsigned values.
- If the digits differ (EARLY_EXIT_EN defined), or idx == N-1: write the result flags, set digits to idx+1, set done<=1, go to DONE.
- Otherwise shift a_sr and b_sr left by D, increment idx, stay in RUN.
- Result flags:
  - first differing digit decides: A digit > B digit gives agtb=1; A digit < B digit gives altb=1.
  - no differing digit across all N gives aeqb=1.
  - exactly one flag is high once any result exists.
- DONE: done=1 and ready=0 for exactly one cycle, then unconditionally go to IDLE.
- start during DONE is ignored. A new start is accepted on the first IDLE cycle.
- start while in RUN or DONE is ignored. a and b may change freely once accepted; captured values are used.
- Latency, counting the accepting edge as E0:
  - decision at edge E_k, k = digits (1..N).
  - done high in the cycle after E_k.
  - ready high again one edge later.
- Result flags and digits update at the same edge done rises. They remain stable until the next decision.
- Back-to-back throughput: one compare per digits+2 cycles.
- Degenerate case D=W: N=1, every compare takes exactly one RUN cycle.

Optional Feature:
- Macro: SEQ_MAG_CMP_EARLY_EXIT_EN.
- Defined: RUN terminates at the first differing digit. Latency is data-dependent and digits ranges 1..N.
- Undefined: RUN always processes all N digits, giving constant latency.
  - The decision is still taken from the first differing digit, latched internally.
  - digits always reads N.
  - Flag values are identical in both builds.

Test Plan:
- Exhaustive, W=2, D=1, early exit on: all 16 (a,b) pairs 00..11. Required: exactly one flag high, matching the 2-bit gt truth table; aeqb=1 only when a==b; done asserted once per start.
- W=8, D=2, early exit on: a=8'hA5, b=8'h5A. Required: agtb=1, digits=1, done in cycle E1+1. Early exit off: same flags, digits=4, done in cycle E4+1.
- W=8, D=2, any build: a=8'h3C, b=8'h3C gives aeqb=1, digits=4. Then a=8'h12, b=8'h13 gives altb=1, digits=4.
- Busy handling: pulse start in RUN with a=8'hFF, b=8'h00. Required: ignored; result reflects the first operands, and ready stays 0 until the cycle after done.
- Reset mid-op: drop reset_n at edge E2 of a 4-digit compare. Required: immediately ready=1, done=0, all flags 0, digits=0. No done pulse follows, and a fresh start then completes normally.
